// File: rtl/result_collector_pp_pkg.sv
// Shared definitions for the ping-pong result collector: defaults, FSM state type and
// the frame-size helper used by the start check.
package result_collector_pp_pkg;

  localparam int RC_ACC_WIDTH = 32;
  localparam int RC_NUM_CH    = 6;
  localparam int RC_DEPTH     = 576;
  localparam int RC_OUT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } rc_state_e;

  // Full 32-bit product so oversized frames cannot alias into the legal range.
  function automatic logic [31:0] rc_total(input logic [15:0] w, input logic [15:0] h);
    return 32'(w) * 32'(h);
  endfunction

endpackage

// File: rtl/result_collector_pp_requant_unit.sv
// Two-stage per-channel ReLU / round / shift / saturate. Raw mode passes the (optionally
// ReLU'd) accumulator through unchanged; latency is two cycles in both modes.
module requant_unit #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_async_n_i,
  input  logic                 mode_i,
  input  logic                 relu_en_i,
  input  logic [4:0]           shift_i,
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [ACC_WIDTH-1:0] res_o
);

  // One guard bit so the rounding add on a near-max positive value cannot wrap.
  localparam int W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] SAT_MAX = $signed(W'(2 ** (OUT_WIDTH - 1) - 1));
  localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [W-1:0]   relu_v;
  logic signed [W-1:0]   s1_d;
  logic signed [W-1:0]   s1_q;
  logic signed [W-1:0]   shifted;
  logic                  s1_mode_q;
  logic [4:0]            s1_shift_q;
  logic [ACC_WIDTH-1:0]  res_d;

  always_comb begin
    relu_v = {acc_i[ACC_WIDTH-1], acc_i};
    if (relu_en_i && acc_i[ACC_WIDTH-1]) relu_v = '0;
    s1_d = relu_v;
    if (mode_i && (shift_i != 5'd0)) s1_d = relu_v + (W'(1) << (shift_i - 5'd1));
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      s1_q       <= '0;
      s1_mode_q  <= 1'b0;
      s1_shift_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_mode_q  <= mode_i;
      s1_shift_q <= shift_i;
    end
  end

  always_comb begin
    shifted = s1_q >>> s1_shift_q;
    if (!s1_mode_q)              res_d = s1_q[ACC_WIDTH-1:0];
    else if (shifted > SAT_MAX)  res_d = SAT_MAX[ACC_WIDTH-1:0];
    else if (shifted < SAT_MIN)  res_d = SAT_MIN[ACC_WIDTH-1:0];
    else                         res_d = shifted[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) res_o <= '0;
    else                res_o <= res_d;
  end

endmodule

// File: rtl/result_collector_pp.sv
// Collects NUM_CH-wide output pixels into ping-pong per-channel banks; the completed
// frame stays readable while the next one is written into the other bank.
//
//  state   | meaning
//  IDLE    | waiting for a start with a legal frame size
//  COLLECT | accepting pixels, address = pixel counter
//  DRAIN   | two cycles for the requant pipeline to land its last write
//  DONE    | one-cycle done pulse, banks swap at the end of it
module result_collector_pp
  import result_collector_pp_pkg::*;
#(
  parameter int NUM_CH    = RC_NUM_CH,
  parameter int ACC_WIDTH = RC_ACC_WIDTH,
  parameter int OUT_WIDTH = RC_OUT_WIDTH,
  parameter int DEPTH     = RC_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_async_n_i,
  input  logic [15:0]                 cfg_out_w_i,
  input  logic [15:0]                 cfg_out_h_i,
  input  logic                        cfg_mode_i,
  input  logic                        cfg_relu_en_i,
  input  logic [4:0]                  cfg_shift_i,
  input  logic                        start_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [NUM_CH*ACC_WIDTH-1:0] in_data_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  input  logic                        rd_en_i,
  input  logic [CH_W-1:0]             rd_ch_i,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  output logic                        rd_valid_o,
  output logic [ACC_WIDTH-1:0]        rd_data_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CH_W:0]   NCH_L   = (CH_W + 1)'(NUM_CH);

  rc_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, last_q, a1_q, a2_q;
  logic                  v1_q, v2_q, drain_q;
  logic                  wr_bank_q, rd_bank_q;
  logic                  mode_q, relu_q;
  logic [4:0]            shift_q;
  logic [31:0]           total;
  logic                  total_ok, start_ok, accept, rd_ok, err_set;
  logic [ACC_WIDTH-1:0]  res [NUM_CH];
  logic [ACC_WIDTH-1:0]  rd_word [NUM_CH];

  always_comb begin
    total    = rc_total(cfg_out_w_i, cfg_out_h_i);
    total_ok = (total != 32'd0) && (total <= 32'(DEPTH));
    start_ok = (state_q == IDLE) && start_i && total_ok;
    accept   = in_valid_i && in_ready_o;
    rd_ok    = ({1'b0, rd_ch_i} < NCH_L) && ({1'b0, rd_addr_i} < DEPTH_L);
    err_set  = ((state_q == IDLE) && start_i && !total_ok)
             || (in_valid_i && (state_q != COLLECT))
             || (rd_en_i && !rd_ok);
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = COLLECT;
      COLLECT: if (accept && (cnt_q == last_q)) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == COLLECT);
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      cnt_q      <= '0;
      last_q     <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      drain_q    <= 1'b0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b1;
      mode_q     <= 1'b0;
      relu_q     <= 1'b0;
      shift_q    <= '0;
      err_o      <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      if (start_ok) begin
        mode_q  <= cfg_mode_i;
        relu_q  <= cfg_relu_en_i;
        shift_q <= cfg_shift_i;
        last_q  <= ADDR_W'(total - 32'd1);
        cnt_q   <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + ADDR_W'(1);
      end
      // Address travels alongside the requant pipeline so the write lands two cycles later.
      v1_q    <= accept;
      a1_q    <= cnt_q;
      v2_q    <= v1_q;
      a2_q    <= a1_q;
      drain_q <= (state_q == DRAIN) && !drain_q;
      if (state_q == DONE) begin
        rd_bank_q <= wr_bank_q;
        wr_bank_q <= ~wr_bank_q;
      end
      if (err_set)       err_o <= 1'b1;
      else if (start_ok) err_o <= 1'b0;
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_ok ? rd_word[rd_ch_i] : '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_WIDTH-1:0] bank_q [2][DEPTH];

    requant_unit #(
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_rq (
      .clk_i        (clk_i),
      .rst_async_n_i(rst_async_n_i),
      .mode_i       (mode_q),
      .relu_en_i    (relu_q),
      .shift_i      (shift_q),
      .acc_i        (in_data_i[c*ACC_WIDTH +: ACC_WIDTH]),
      .res_o        (res[c])
    );

    always_ff @(posedge clk_i) begin
      if (v2_q) bank_q[wr_bank_q][a2_q] <= res[c];
    end

    assign rd_word[c] = bank_q[rd_bank_q][rd_addr_i];
  end

endmodule

// File: tb/tb_result_collector_pp.sv
// Directed + randomized bench for result_collector_pp with a frame-level reference model.
module tb_result_collector_pp;

  localparam int NCH    = 6;
  localparam int AW     = 32;
  localparam int DEPTH  = 576;
  localparam int ADDR_W = 10;
  localparam int CH_W   = 3;

  logic              clk_i = 1'b0;
  logic              rst_async_n_i = 1'b0;
  logic [15:0]       cfg_out_w_i = '0;
  logic [15:0]       cfg_out_h_i = '0;
  logic              cfg_mode_i = 1'b0;
  logic              cfg_relu_en_i = 1'b0;
  logic [4:0]        cfg_shift_i = '0;
  logic              start_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [NCH*AW-1:0] in_data_i = '0;
  logic              busy_o, done_o, err_o;
  logic              rd_en_i = 1'b0;
  logic [CH_W-1:0]   rd_ch_i = '0;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic              rd_valid_o;
  logic [AW-1:0]     rd_data_o;

  result_collector_pp dut (
    .clk_i(clk_i), .rst_async_n_i(rst_async_n_i),
    .cfg_out_w_i(cfg_out_w_i), .cfg_out_h_i(cfg_out_h_i), .cfg_mode_i(cfg_mode_i),
    .cfg_relu_en_i(cfg_relu_en_i), .cfg_shift_i(cfg_shift_i), .start_i(start_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_en_i(rd_en_i), .rd_ch_i(rd_ch_i), .rd_addr_i(rd_addr_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;

  logic [31:0] pix     [DEPTH][NCH];
  logic [31:0] exp_cur [DEPTH][NCH];
  logic [31:0] exp_rd  [DEPTH][NCH];
  int          rd_n = 0;
  bit          m_mode, m_relu;
  int          m_shift;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] model(logic [31:0] acc, bit mode, bit relu, int sh);
    longint v;
    v = longint'($signed(acc));
    if (relu && v < 0) v = 0;
    if (mode) begin
      if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] rand_acc();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 4000)) - 32'd2000;
      1: return 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
      2: return 32'h8000_0000 + 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic fill_rand(int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < NCH; c++) pix[p][c] = rand_acc();
  endtask

  task automatic start_frame(int w, int h, bit mode, bit relu, int sh);
    cfg_out_w_i = 16'(w); cfg_out_h_i = 16'(h);
    cfg_mode_i = mode; cfg_relu_en_i = relu; cfg_shift_i = 5'(sh);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    m_mode = mode; m_relu = relu; m_shift = sh;
    chk("start_busy", busy_o, 1);
    chk("start_err_clear", err_o, 0);
  endtask

  // Streams pix[0..n-1]; gaps=1 toggles in_valid_i; do_rd reads the previous frame each cycle.
  task automatic run_frame(int n, bit gaps, bit do_rd);
    int p = 0;
    int cyc = 0;
    bit acc_now, rchk;
    logic [31:0] rexp;
    while (p < n && cyc < 4 * n + 20) begin
      in_valid_i = !gaps || (cyc % 2 == 0);
      for (int c = 0; c < NCH; c++) in_data_i[c*AW +: AW] = pix[p][c];
      rchk = do_rd && (rd_n > 0);
      if (rchk) begin
        rd_en_i = 1'b1;
        rd_ch_i = CH_W'($urandom_range(0, NCH - 1));
        rd_addr_i = ADDR_W'($urandom_range(0, rd_n - 1));
        rexp = exp_rd[rd_addr_i][rd_ch_i];
      end
      acc_now = in_valid_i && in_ready_o;
      tick();
      if (rchk) begin
        chk("rd_during_collect", rd_data_o, rexp);
        rd_en_i = 1'b0;
      end
      if (acc_now) begin
        for (int c = 0; c < NCH; c++) exp_cur[p][c] = model(pix[p][c], m_mode, m_relu, m_shift);
        p++;
      end
      cyc++;
    end
    in_valid_i = 1'b0;
    chk("frame_accept_count", p, n);
    if (p == n) begin
      chk("drain_not_ready", in_ready_o, 0);
      chk("done_lat1", done_o, 0);
      tick();
      chk("done_lat2", done_o, 0);
      tick();
      chk("done_lat3", done_o, 1);
      if (rd_n > 0) begin
        rd_en_i = 1'b1; rd_ch_i = '0; rd_addr_i = '0;
        rexp = exp_rd[0][0];
      end
      tick();
      if (rd_n > 0) begin
        chk("rd_in_done_old_bank", rd_data_o, rexp);
        rd_en_i = 1'b0;
      end
      chk("done_one_cycle", done_o, 0);
      chk("idle_after_done", busy_o, 0);
      exp_rd = exp_cur;
      rd_n = n;
    end
  endtask

  task automatic rd_check(string tag, int ch, int addr, logic [31:0] exp);
    rd_en_i = 1'b1; rd_ch_i = CH_W'(ch); rd_addr_i = ADDR_W'(addr);
    tick();
    rd_en_i = 1'b0;
    chk({tag, "_valid"}, rd_valid_o, 1);
    chk(tag, rd_data_o, exp);
  endtask

  task automatic rd_all();
    for (int p = 0; p < rd_n; p++)
      for (int c = 0; c < NCH; c++) rd_check("rd_frame", c, p, exp_rd[p][c]);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    #1 rst_async_n_i = 1'b1;
    tick();

    // Raw 2x2 frame: value 100*p + c
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < NCH; c++) pix[p][c] = 32'(100 * p + c);
    start_frame(2, 2, 1'b0, 1'b0, 0);
    run_frame(4, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < NCH; c++) rd_check("raw_2x2", c, p, 32'(100 * p + c));

    // Requant, shift 4, ReLU on
    fill_rand(1);
    pix[0][0] = -32'sd50; pix[0][1] = 32'd24; pix[0][2] = 32'd5000;
    start_frame(1, 1, 1'b1, 1'b1, 4);
    run_frame(1, 1'b0, 1'b1);
    rd_check("rq_relu_neg", 0, 0, 32'd0);
    rd_check("rq_round", 1, 0, 32'd2);
    rd_check("rq_sat_hi", 2, 0, 32'd127);
    rd_all();

    // Requant, shift 4, ReLU off
    fill_rand(1);
    pix[0][0] = -32'sd5000; pix[0][1] = -32'sd24;
    start_frame(1, 1, 1'b1, 1'b0, 4);
    run_frame(1, 1'b0, 1'b1);
    rd_check("rq_sat_lo", 0, 0, 32'hFFFF_FF80);
    rd_check("rq_neg_round", 1, 0, 32'hFFFF_FFFF);
    rd_all();

    // Ping-pong: A = 1..9, B = 101..109, reads of A while B collects
    for (int p = 0; p < 9; p++)
      for (int c = 0; c < NCH; c++) pix[p][c] = 32'(p + 1 + 1000 * c);
    start_frame(3, 3, 1'b0, 1'b0, 0);
    run_frame(9, 1'b0, 1'b1);
    for (int p = 0; p < 9; p++)
      for (int c = 0; c < NCH; c++) pix[p][c] = 32'(p + 101 + 1000 * c);
    start_frame(3, 3, 1'b0, 1'b0, 0);
    for (int p = 0; p < 9; p++) rd_check("pp_old_frame", 0, p, 32'(p + 1));
    run_frame(9, 1'b0, 1'b1);
    for (int p = 0; p < 9; p++) rd_check("pp_new_frame", 0, p, 32'(p + 101));
    rd_all();

    // Handshake gaps, then a stray in_valid in IDLE
    fill_rand(4);
    start_frame(2, 2, 1'b0, 1'b0, 0);
    run_frame(4, 1'b1, 1'b1);
    rd_all();
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("stray_valid_err", err_o, 1);
    chk("stray_valid_idle", busy_o, 0);

    // Random requant frame; a start while busy is ignored without error
    fill_rand(20);
    start_frame(4, 5, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 31));
    cfg_out_w_i = '0; cfg_mode_i = ~cfg_mode_i; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_busy_ignored", busy_o, 1);
    chk("start_busy_no_err", err_o, 0);
    run_frame(20, 1'b0, 1'b1);
    rd_all();

    // Zero-size start is rejected
    cfg_out_w_i = 16'd0; cfg_out_h_i = 16'd5; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("bad_cfg_busy", busy_o, 0);
    chk("bad_cfg_err", err_o, 1);
    tick();
    chk("bad_cfg_stays_idle", busy_o, 0);

    // Full-depth 24x24 frame, raw with ReLU
    fill_rand(DEPTH);
    start_frame(24, 24, 1'b0, 1'b1, 0);
    run_frame(DEPTH, 1'b0, 1'b1);
    rd_check("full_last", NCH - 1, DEPTH - 1, model(pix[DEPTH-1][NCH-1], 1'b0, 1'b1, 0));
    for (int k = 0; k < 30; k++) begin
      int p, c;
      p = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(0, NCH - 1);
      rd_check("full_rand", c, p, exp_rd[p][c]);
    end
    rd_en_i = 1'b1; rd_ch_i = '0; rd_addr_i = ADDR_W'(DEPTH);
    tick();
    rd_en_i = 1'b0;
    chk("bad_addr_valid", rd_valid_o, 1);
    chk("bad_addr_data", rd_data_o, 0);
    chk("bad_addr_err", err_o, 1);

    // Reset in the middle of COLLECT
    fill_rand(4);
    start_frame(2, 2, 1'b0, 1'b0, 0);
    in_valid_i = 1'b1;
    for (int c = 0; c < NCH; c++) in_data_i[c*AW +: AW] = pix[0][c];
    tick();
    tick();
    in_valid_i = 1'b0;
    rd_en_i = 1'b1; rd_ch_i = CH_W'(NCH); rd_addr_i = '0;
    tick();
    chk("bad_ch_valid", rd_valid_o, 1);
    chk("bad_ch_data", rd_data_o, 0);
    chk("bad_ch_err", err_o, 1);
    chk("mid_collect_busy", busy_o, 1);
    rd_ch_i = '0;
    #2 rst_async_n_i = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_err", err_o, 0);
    chk("midrst_rd_valid", rd_valid_o, 0);
    chk("midrst_rd_data", rd_data_o, 0);
    rd_en_i = 1'b0;
    rd_n = 0;
    #3 rst_async_n_i = 1'b1;
    tick();
    start_frame(2, 2, 1'b0, 1'b0, 0);
    run_frame(4, 1'b0, 1'b0);
    rd_all();

    // One pixel over depth is rejected
    cfg_out_w_i = 16'd1; cfg_out_h_i = 16'(DEPTH + 1); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("over_depth_busy", busy_o, 0);
    chk("over_depth_err", err_o, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/result_collector_pp.md
Name: result_collector_pp

Overview:
- Parametrised successor to the conv result handler. Sits behind the systolic array in systolic_wrapper.
- Accepts one NUM_CH-wide output pixel per handshake and optionally applies ReLU plus shift-round-saturate requantisation.
- Stores pixels in double-buffered (ping-pong) per-channel banks. A completed frame can be read out while the next frame is being collected.

Parameters:
- NUM_CH, 6, output channels per pixel (one bank pair per channel).
- ACC_WIDTH, 32, width of incoming accumulator values and of stored words.
- OUT_WIDTH, 8, saturation width in requant mode.
- DEPTH, 576, maximum pixels per frame per bank.
- ADDR_W, $clog2(DEPTH), derived, pixel address width.

Ports:
- clk_i  in  1  clock.
- rst_async_n_i  in  1  reset; asynchronous, active-low.
- cfg_out_w_i  in  16  output frame width; sampled at accepted start.
- cfg_out_h_i  in  16  output frame height; sampled at accepted start.
- cfg_mode_i  in  1  0 = raw store, 1 = requant.
- cfg_relu_en_i  in  1  clamp negatives to 0 before requant/store.
- cfg_shift_i  in  5  requant right-shift amount.
- start_i  in  1  begin collecting a frame.
- in_valid_i  in  1  pixel valid.
- in_ready_o  out  1  collector can accept a pixel.
- in_data_i  in  NUM_CH x ACC_WIDTH  signed pixel, all channels.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at frame completion.
- err_o  out  1  sticky error flag; cleared by the next accepted start.
- rd_en_i  in  1  read request on the completed bank.
- rd_ch_i  in  $clog2(NUM_CH)  channel select.
- rd_addr_i  in  ADDR_W  pixel index, row-major.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  ACC_WIDTH  read data.

Behaviour:
- Reset values:
  - in_ready_o=0, busy_o=0, done_o=0, err_o=0, rd_valid_o=0, rd_data_o=0.
  - FSM=IDLE, wr_bank=0, rd_bank=1, pixel counter=0.
  - Bank memory contents are not reset.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - start_i with total=out_w*out_h in [1,DEPTH] latches cfg, clears err_o and the counter, then goes to COLLECT.
  - Invalid total ignores the start and sets err_o.
- COLLECT:
  - in_ready_o=1.
  - Each cycle with in_valid_i&&in_ready_o writes the pixel to address = counter, then increments the counter.
  - Accepting pixel total-1 goes to DRAIN.
- Pipeline: 2 stages.
  - S1: ReLU, round-add.
  - S2: shift/saturate plus bank write.
  - Every accepted pixel is written exactly 2 cycles after acceptance.
- DRAIN: in_ready_o=0. Waits until the pipeline is empty (2 cycles), then goes to DONE.
- DONE (1 cycle):
  - done_o=1.
  - Swap: rd_bank<=wr_bank, wr_bank<=~wr_bank.
  - Return to IDLE.
- done_o therefore rises exactly 3 cycles after the last pixel is accepted.
- busy_o=1 in COLLECT, DRAIN and DONE.
- start_i while busy is ignored; err_o is not set.
- in_valid_i outside COLLECT: pixel dropped, err_o set.
- Raw mode: stored value = in_data (ReLU applied if enabled).
- Requant mode, per channel:
  - v = relu ? max(acc,0) : acc.
  - If shift>0, v = (v + 2^(shift-1)) >>> shift, arithmetic shift, computed in ACC_WIDTH+1 bits to avoid overflow.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Store sign-extended to ACC_WIDTH.
- Read port:
  - rd_en_i returns bank[rd_bank][rd_ch_i][rd_addr_i] with 1-cycle latency; rd_valid_o=1 in that cycle.
  - rd_addr_i>=DEPTH or rd_ch_i>=NUM_CH returns 0 with rd_valid_o=1 and sets err_o.
- Reads are legal in any state, concurrent with writes (different bank). A read in the DONE cycle sees the pre-swap rd_bank.
- Reset mid-frame returns to reset values immediately; partially written bank content is undefined.

Decomposition:
- Shared package (definitions.sv):
  - Add RC_NUM_CH, RC_DEPTH, RC_OUT_WIDTH defaults.
  - Add typedef rc_state_e {IDLE, COLLECT, DRAIN, DONE}.
  - Reuse ACC_WIDTH.
- Sub-module requant_unit: one instance per channel, 2-stage pipelined ReLU/round/shift/saturate, parameters ACC_WIDTH and OUT_WIDTH.
- Banks: inferred arrays in the top module.

Test Plan:
- Raw frame, 2x2, NUM_CH=6: pixel p, channel c = 100*p+c.
  - Every read returns 100*p+c.
  - done_o is a 1-cycle pulse exactly 3 cycles after the 4th accept.
- Requant, shift=4, relu=1:
  - acc -50 -> 0; 24 -> 2; 5000 -> 127.
  - With relu=0: -5000 -> -128; -24 -> -1.
- Ping-pong, 3x3: frame A values 1..9, then start frame B values 101..109.
  - Reads during B's COLLECT return 1..9.
  - After B's done_o, reads return 101..109.
- Handshake gaps: in_valid_i toggling 1/0 across 4 pixels gives correct addresses 0..3.
  - An extra in_valid_i after DONE sets err_o.
  - The next valid start clears err_o.
- Bad config: out_w=0 -> start ignored, busy_o stays 0, err_o=1.
  - start_i while busy: no effect.
- Reset asserted mid-COLLECT: all outputs 0 and FSM in IDLE within the same cycle.
  - A subsequent 2x2 frame completes normally.
